// File: rtl/stream_arbiter_pkg.sv
// Shared types and constants for the burst-framing stream arbiter.
// Header: {tag, 4'h0, ch, seq}; trailer: {tag, 8'h00, count}.
package stream_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_DATA    = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    localparam logic [7:0] DEF_HDR_TAG = 8'hA5;
    localparam logic [7:0] DEF_TRL_TAG = 8'h5A;

    localparam int unsigned TAG_MSB = 31;
    localparam int unsigned TAG_LSB = 24;
    localparam int unsigned CH_MSB  = 19;
    localparam int unsigned CH_LSB  = 16;
    localparam int unsigned SEQ_MSB = 15;
    localparam int unsigned SEQ_LSB = 0;
    localparam int unsigned CNT_MSB = 15;
    localparam int unsigned CNT_LSB = 0;

    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Producer-side request bus and FX3 stream write side of the arbiter.
interface stream_arbiter_if #(
    parameter int unsigned N_CH = 2
);
    logic [N_CH*32-1:0] req_data_i;
    logic [N_CH-1:0]    req_valid_i;
    logic [N_CH-1:0]    req_ready_o;
    logic [31:0]        stream_data_o;
    logic               stream_write_o;
    logic               stream_full_i;

    modport master (
        input  req_data_i, req_valid_i, stream_full_i,
        output req_ready_o, stream_data_o, stream_write_o
    );

    modport slave (
        output req_data_i, req_valid_i, stream_full_i,
        input  req_ready_o, stream_data_o, stream_write_o
    );
endinterface

// File: rtl/stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, with wrap.
module rr_pick #(
    parameter int unsigned N_CH = 2
) (
    input  logic [N_CH-1:0] req_valid,
    input  logic [3:0]      ptr,
    output logic [N_CH-1:0] grant,
    output logic            found
);
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   sel;
    logic [2*N_CH-1:0] sel_wide;

    // Rotate so the pointer lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot   = N_CH'({req_valid, req_valid} >> ptr);
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && rot[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        sel_wide = {{N_CH{1'b0}}, sel} << ptr;
        grant    = sel_wide[N_CH-1:0] | sel_wide[2*N_CH-1:N_CH];
    end
endmodule

// File: rtl/stream_arbiter.sv
// Burst round-robin arbiter in front of the FX3 stream FIFO write port.
// Each burst is framed by a header (channel, sequence) and a trailer (word count).
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned MAX_BURST = 256,
    parameter logic [7:0]  HDR_TAG   = DEF_HDR_TAG,
    parameter logic [7:0]  TRL_TAG   = DEF_TRL_TAG
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable_i,
    stream_arbiter_if.master   bus,
    output logic [N_CH-1:0]    grant_o,
    output logic               busy_o
);
    localparam logic [15:0] LAST_CNT = 16'(MAX_BURST - 1);
    localparam logic [3:0]  LAST_CH  = 4'(N_CH - 1);

    state_t                 state;
    logic [3:0]             ch_q;
    logic [3:0]             ptr_q;
    logic [15:0]            cnt_q;
    logic [N_CH-1:0][15:0]  seq_q;

    logic [N_CH-1:0] pick_grant;
    logic            pick_found;

    logic        cur_valid;
    logic [31:0] cur_data;
    logic [15:0] cur_seq;
    logic [31:0] hdr_word;
    logic [31:0] trl_word;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req_valid (bus.req_valid_i),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .found     (pick_found)
    );

    // grant_o doubles as the one-hot select of the current owner
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        cur_seq   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant_o[i]) begin
                cur_valid = bus.req_valid_i[i];
                cur_data  = bus.req_data_i[32*i +: 32];
                cur_seq   = seq_q[i];
            end
        end
    end

    always_comb begin
        hdr_word                  = '0;
        hdr_word[TAG_MSB:TAG_LSB] = HDR_TAG;
        hdr_word[CH_MSB:CH_LSB]   = ch_q;
        hdr_word[SEQ_MSB:SEQ_LSB] = cur_seq;
        trl_word                  = '0;
        trl_word[TAG_MSB:TAG_LSB] = TRL_TAG;
        trl_word[CNT_MSB:CNT_LSB] = cnt_q;
    end

    always_comb begin
        bus.stream_write_o = 1'b0;
        bus.stream_data_o  = '0;
        bus.req_ready_o    = '0;
        case (state)
            ST_HEADER: begin
                bus.stream_write_o = !bus.stream_full_i;
                bus.stream_data_o  = hdr_word;
            end
            ST_DATA: begin
                bus.stream_data_o = cur_data;
                if (cur_valid && !bus.stream_full_i) begin
                    bus.stream_write_o = 1'b1;
                    bus.req_ready_o    = grant_o;
                end
            end
            ST_TRAILER: begin
                bus.stream_write_o = !bus.stream_full_i;
                bus.stream_data_o  = trl_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_i && pick_found) begin
                        grant_o <= pick_grant;
                        ch_q    <= onehot_to_idx(16'(pick_grant));
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (!bus.stream_full_i) begin
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            if (grant_o[i]) seq_q[i] <= seq_q[i] + 16'd1;
                        end
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // A stall freezes the burst, even across a valid gap.
                    if (!bus.stream_full_i) begin
                        if (cur_valid) begin
                            cnt_q <= cnt_q + 16'd1;
                            if (cnt_q == LAST_CNT) state <= ST_TRAILER;
                        end else begin
                            state <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (!bus.stream_full_i) begin
                        ptr_q   <= (ch_q == LAST_CH) ? '0 : ch_q + 4'd1;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
